// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller slice.
//   dbn_state_t : farm-road sensor debounce states (2-bit encoding)
//   LIGHT_*     : one-hot light encodings shared with the light controller
package tlc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RISE_WAIT = 2'd1,
    PRESENT   = 2'd2,
    FALL_WAIT = 2'd3
  } dbn_state_t;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

endpackage

// File: rtl/tlc_sync2.sv
// Two-flop synchroniser with synchronous active-high reset.
//   clk : sampling clock
//   rst : synchronous reset, clears both flops
//   d   : asynchronous input
//   q   : synchronised output (second flop)
module tlc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tlc_farm_sensor_cond.sv
// Farm-road vehicle sensor conditioner: synchronises and debounces the pad
// input, latches a vehicle request until the farm road is served, counts
// waiting vehicles and flags a sensor stuck in the PRESENT state.
//   clk         : single clock, posedge
//   rst         : synchronous active-high reset
//   sensor_raw  : asynchronous pad input, 1 = vehicle detected
//   farm_served : 1 while the farm light is green
//   req_c       : registered request to the light controller C input
//   veh_present : debounced sensor level
//   wait_count  : vehicles arrived since last service, saturating
//   stuck_fault : sticky stuck-sensor flag, forces req_c high
module tlc_farm_sensor_cond
  import tlc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STUCK_CYCLES    = 4096,
  parameter int unsigned CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_raw,
  input  logic             farm_served,
  output logic             req_c,
  output logic             veh_present,
  output logic [CNT_W-1:0] wait_count,
  output logic             stuck_fault
);

  localparam int unsigned DBN_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned STK_W = $clog2(STUCK_CYCLES);
  localparam logic [DBN_W-1:0] DBN_LAST = DBN_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STK_W-1:0] STK_LAST = STK_W'(STUCK_CYCLES - 1);

  logic             sync_s;
  dbn_state_t       state, next_state;
  logic [DBN_W-1:0] dbn_cnt, next_cnt;
  logic [STK_W-1:0] stk_cnt;
  logic             arrive_d, arrive;
  logic             served_q, served_pulse;
  logic             stk_hit;

  tlc_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sensor_raw),
    .q   (sync_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dbn_cnt <= '0;
      arrive  <= 1'b0;
    end else begin
      state   <= next_state;
      dbn_cnt <= next_cnt;
      arrive  <= arrive_d;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = dbn_cnt;
    arrive_d   = 1'b0;
    case (state)
      IDLE: begin
        if (sync_s) begin
          next_state = RISE_WAIT;
          next_cnt   = DBN_W'(1);
        end
      end
      RISE_WAIT: begin
        if (!sync_s) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else if (dbn_cnt == DBN_LAST) begin
          next_state = PRESENT;
          next_cnt   = '0;
          arrive_d   = 1'b1;
        end else begin
          next_cnt = dbn_cnt + DBN_W'(1);
        end
      end
      PRESENT: begin
        if (!sync_s) begin
          next_state = FALL_WAIT;
          next_cnt   = DBN_W'(1);
        end
      end
      FALL_WAIT: begin
        if (sync_s) begin
          next_state = PRESENT;
          next_cnt   = '0;
        end else if (dbn_cnt == DBN_LAST) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = dbn_cnt + DBN_W'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  assign veh_present  = (state == PRESENT) || (state == FALL_WAIT);
  assign served_pulse = farm_served & ~served_q;
  assign stk_hit      = (stk_cnt == STK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      served_q    <= 1'b0;
      stk_cnt     <= '0;
      stuck_fault <= 1'b0;
      req_c       <= 1'b0;
      wait_count  <= '0;
    end else begin
      served_q <= farm_served;

      if (state == PRESENT) begin
        if (!stk_hit) stk_cnt <= stk_cnt + STK_W'(1);
      end else begin
        stk_cnt <= '0;
      end

      if (stk_hit) stuck_fault <= 1'b1;

      // Fault forces the request on the same edge the flag rises, so the
      // farm road keeps being served even with a dead sensor.
      if (stuck_fault || stk_hit) req_c <= 1'b1;
      else if (arrive)            req_c <= 1'b1;
      else if (served_pulse)      req_c <= 1'b0;

      case ({arrive, served_pulse})
        2'b10:   if (wait_count != '1) wait_count <= wait_count + CNT_W'(1);
        2'b01:   wait_count <= '0;
        2'b11:   wait_count <= CNT_W'(1);
        default: wait_count <= wait_count;
      endcase
    end
  end

endmodule

// File: tb/tb_tlc_farm_sensor_cond.sv
// Directed self-checking bench for tlc_farm_sensor_cond.
// Inputs change 1 time unit after a posedge; outputs are checked at that same point.
module tb_tlc_farm_sensor_cond;

  localparam int unsigned DEB = 16;
  localparam int unsigned STK = 4096;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sensor_raw;
  logic          farm_served;
  logic          req_c;
  logic          veh_present;
  logic [CW-1:0] wait_count;
  logic          stuck_fault;

  int checks = 0;
  int errors = 0;

  tlc_farm_sensor_cond #(
    .DEBOUNCE_CYCLES (DEB),
    .STUCK_CYCLES    (STK),
    .CNT_W           (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sensor_raw  (sensor_raw),
    .farm_served (farm_served),
    .req_c       (req_c),
    .veh_present (veh_present),
    .wait_count  (wait_count),
    .stuck_fault (stuck_fault)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req_c"},       32'(req_c),       32'd0);
    chk({tag, ".veh_present"}, 32'(veh_present), 32'd0);
    chk({tag, ".wait_count"},  32'(wait_count),  32'd0);
    chk({tag, ".stuck_fault"}, 32'(stuck_fault), 32'd0);
  endtask

  // Full debounced press and release; ends with the debouncer back in IDLE.
  task automatic arrival();
    sensor_raw = 1'b1;
    step(19);
    sensor_raw = 1'b0;
    step(18);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sensor_raw = 1'b0;
    farm_served = 1'b0;
    step(2);
    chk_all_zero("reset");
    rst = 1'b0;
    step(1);

    // 1) latency of a held press
    sensor_raw = 1'b1;
    step(17);
    chk("t1.veh_pre", 32'(veh_present), 32'd0);
    step(1);
    chk("t1.veh_rise", 32'(veh_present), 32'd1);
    chk("t1.req_pre", 32'(req_c), 32'd0);
    step(1);
    chk("t1.req_rise", 32'(req_c), 32'd1);
    chk("t1.wc", 32'(wait_count), 32'd1);
    sensor_raw = 1'b0;
    step(17);
    chk("t1.veh_fall_wait", 32'(veh_present), 32'd1);
    step(1);
    chk("t1.veh_fall", 32'(veh_present), 32'd0);
    chk("t1.req_held", 32'(req_c), 32'd1);
    farm_served = 1'b1;
    step(1);
    chk("t1.req_served", 32'(req_c), 32'd0);
    chk("t1.wc_served", 32'(wait_count), 32'd0);
    farm_served = 1'b0;
    step(1);

    // 2) 10-cycle glitch is rejected
    sensor_raw = 1'b1;
    step(10);
    sensor_raw = 1'b0;
    step(5);
    chk("t2.veh_mid", 32'(veh_present), 32'd0);
    step(25);
    chk("t2.veh", 32'(veh_present), 32'd0);
    chk("t2.req", 32'(req_c), 32'd0);
    chk("t2.wc", 32'(wait_count), 32'd0);

    // 3) three arrivals then service; held farm_served clears nothing further
    arrival();
    arrival();
    arrival();
    chk("t3.wc3", 32'(wait_count), 32'd3);
    chk("t3.req1", 32'(req_c), 32'd1);
    farm_served = 1'b1;
    step(1);
    chk("t3.wc_clr", 32'(wait_count), 32'd0);
    chk("t3.req_clr", 32'(req_c), 32'd0);
    arrival();
    chk("t3.req_held_served", 32'(req_c), 32'd1);
    chk("t3.wc_held_served", 32'(wait_count), 32'd1);
    step(5);
    chk("t3.req_still", 32'(req_c), 32'd1);
    farm_served = 1'b0;
    step(1);

    // 4) arrival coincident with served rise, then saturation
    sensor_raw = 1'b1;
    step(18);
    farm_served = 1'b1;
    step(1);
    chk("t4.req_both", 32'(req_c), 32'd1);
    chk("t4.wc_both", 32'(wait_count), 32'd1);
    sensor_raw = 1'b0;
    farm_served = 1'b0;
    step(18);
    repeat (13) arrival();
    chk("t4.wc14", 32'(wait_count), 32'd14);
    arrival();
    chk("t4.wc15", 32'(wait_count), 32'd15);
    repeat (3) arrival();
    chk("t4.wc_sat", 32'(wait_count), 32'd15);

    // 5) stuck sensor
    farm_served = 1'b1;
    step(1);
    chk("t5.wc_clr", 32'(wait_count), 32'd0);
    farm_served = 1'b0;
    step(1);
    sensor_raw = 1'b1;
    step(18 + STK - 1);
    chk("t5.stuck_pre", 32'(stuck_fault), 32'd0);
    chk("t5.veh", 32'(veh_present), 32'd1);
    chk("t5.wc1", 32'(wait_count), 32'd1);
    step(1);
    chk("t5.stuck", 32'(stuck_fault), 32'd1);
    chk("t5.req", 32'(req_c), 32'd1);
    farm_served = 1'b1;
    step(1);
    chk("t5.req_forced", 32'(req_c), 32'd1);
    chk("t5.wc_served", 32'(wait_count), 32'd0);
    chk("t5.stuck_sticky", 32'(stuck_fault), 32'd1);
    farm_served = 1'b0;
    step(1);
    rst = 1'b1;
    sensor_raw = 1'b0;
    step(1);
    chk_all_zero("t5.rst");
    rst = 1'b0;
    step(1);

    // 6) reset during RISE_WAIT and during PRESENT
    sensor_raw = 1'b1;
    step(8);
    rst = 1'b1;
    step(1);
    chk_all_zero("t6.rst_rise");
    rst = 1'b0;
    step(17);
    chk("t6a.veh_pre", 32'(veh_present), 32'd0);
    chk("t6a.req_pre", 32'(req_c), 32'd0);
    step(1);
    chk("t6a.veh", 32'(veh_present), 32'd1);
    chk("t6a.req_lag", 32'(req_c), 32'd0);
    step(1);
    chk("t6a.req", 32'(req_c), 32'd1);
    chk("t6a.wc", 32'(wait_count), 32'd1);
    step(3);
    rst = 1'b1;
    step(1);
    chk_all_zero("t6.rst_present");
    rst = 1'b0;
    step(17);
    chk("t6b.veh_pre", 32'(veh_present), 32'd0);
    step(1);
    chk("t6b.veh", 32'(veh_present), 32'd1);
    chk("t6b.req_lag", 32'(req_c), 32'd0);
    step(1);
    chk("t6b.req", 32'(req_c), 32'd1);
    sensor_raw = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
